// File: rtl/okfifo_pkg.sv
// okfifo_pkg: shared constants and helpers for the FrontPanel pipe-in FIFO.
//   DATA_W_DEF / DEPTH_DEF : default word width and FIFO depth
//   level_w()              : width of the occupancy count, $clog2(depth)+1
//   STAT_*                 : bit positions of the status flags when packed into a WireOut
package okfifo_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 16;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_UNDERFLOW = 3;

  // One extra bit so that a completely full FIFO (level == depth) is representable.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [3:0] pack_status(input logic underflow_seen,
                                             input logic overflow,
                                             input logic full,
                                             input logic empty);
    logic [3:0] w_stat;
    w_stat                 = '0;
    w_stat[STAT_UNDERFLOW] = underflow_seen;
    w_stat[STAT_OVERFLOW]  = overflow;
    w_stat[STAT_FULL]      = full;
    w_stat[STAT_EMPTY]     = empty;
    return w_stat;
  endfunction

endpackage

// File: rtl/okfifo_mem.sv
// okfifo_mem: simple dual-port register array backing the pipe-in FIFO.
//   okClk         : write clock
//   we/waddr/wdata: synchronous write port
//   raddr/rdata   : asynchronous read port (first-word-fall-through head)
// Storage is intentionally not reset; the FIFO qualifies reads with m_valid.
module okfifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              okClk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge okClk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/okpipe_in_fifo.sv
// okpipe_in_fifo: receive FIFO behind an okPipeIn/okBTPipeIn endpoint.
//   okClk, rst_n          : host clock, async active-low reset
//   clear                 : one-cycle synchronous flush (TriggerIn)
//   ep_write, ep_dataout  : pipe write strobe and data
//   ep_ready              : registered block-throttle ready
//   m_data/m_valid/m_ready: first-word-fall-through output stream
//   level, full, empty    : occupancy and derived flags
//   overflow              : sticky, write arrived while full
//   underflow_seen        : sticky, m_ready while empty (diagnostic)
module okpipe_in_fifo
  import okfifo_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                      okClk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      ep_write,
  input  logic [DATA_W-1:0]         ep_dataout,
  output logic                      ep_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [level_w(DEPTH)-1:0] level,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow,
  output logic                      underflow_seen
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = level_w(DEPTH);

  localparam logic [LEVEL_W-1:0] LVL_FULL   = LEVEL_W'(DEPTH);
  // Highest level at which a whole block still fits.
  localparam logic [LEVEL_W-1:0] LVL_THRESH = LEVEL_W'(DEPTH - BLOCK_WORDS);
  localparam logic [LEVEL_W-1:0] LVL_ONE    = LEVEL_W'(1);
  localparam logic [PTR_W-1:0]   PTR_ONE    = PTR_W'(1);

  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LEVEL_W-1:0] r_level;
  logic               r_overflow;
  logic               r_underflow;
  logic               r_ep_ready;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  // Flags come from the registered level only, never from ep_write.
  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == '0);

  // clear outranks both ports; a write while full is dropped even if a pop frees a slot.
  assign w_push = ep_write && !w_full && !clear;
  assign w_pop  = !w_empty && m_ready && !clear;

  okfifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .okClk (okClk),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata (ep_dataout),
    .raddr (r_rd_ptr),
    .rdata (m_data)
  );

  always_ff @(posedge okClk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_ep_ready  <= 1'b1;
    end else if (clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_ep_ready  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LVL_ONE;
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LVL_ONE;
      end
      if (ep_write && w_full) begin
        r_overflow <= 1'b1;
      end
      if (m_ready && w_empty) begin
        r_underflow <= 1'b1;
      end
      // Lags level by one cycle; the threshold leaves room for a full block.
      r_ep_ready <= (r_level <= LVL_THRESH);
    end
  end

  assign level          = r_level;
  assign full           = w_full;
  assign empty          = w_empty;
  assign m_valid        = !w_empty;
  assign overflow       = r_overflow;
  assign underflow_seen = r_underflow;
  assign ep_ready       = r_ep_ready;

endmodule

// File: tb/tb_okpipe_in_fifo.sv
`timescale 1ns/100ps
module tb_okpipe_in_fifo;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 16;
  localparam int LEVEL_W = 5;

  logic               okClk;
  logic               rst_n;
  logic               clear;
  logic               ep_write;
  logic [DATA_W-1:0]  ep_dataout;
  logic               ep_ready;
  logic [DATA_W-1:0]  m_data;
  logic               m_valid;
  logic               m_ready;
  logic [LEVEL_W-1:0] level;
  logic               full;
  logic               empty;
  logic               overflow;
  logic               underflow_seen;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] exp_q[$];

  okpipe_in_fifo #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .BLOCK_WORDS (4)
  ) dut (
    .okClk          (okClk),
    .rst_n          (rst_n),
    .clear          (clear),
    .ep_write       (ep_write),
    .ep_dataout     (ep_dataout),
    .ep_ready       (ep_ready),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .level          (level),
    .full           (full),
    .empty          (empty),
    .overflow       (overflow),
    .underflow_seen (underflow_seen)
  );

  initial begin
    okClk = 1'b0;
    forever #5 okClk = ~okClk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus; the expected word is queued if the model says it is accepted.
  task automatic step(input logic we, input logic [31:0] d, input logic rdy, input logic clr);
    logic acc;
    ep_write   = we;
    ep_dataout = d;
    m_ready    = rdy;
    clear      = clr;
    acc = we && !clr && (exp_q.size() < DEPTH);
    @(posedge okClk);
    if (clr) exp_q.delete();
    if (acc) exp_q.push_back(d);
    #1;
  endtask

  task automatic chk_level(input string name);
    chk(name, 32'(level), 32'(exp_q.size()));
  endtask

  // Monitor: a word presented with m_ready high is consumed at the next edge.
  initial begin
    forever begin
      @(negedge okClk);
      if (rst_n && m_valid && m_ready && !clear) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=0x%08h required=none", m_data);
        end else begin
          chk("stream_data", m_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    clear      = 1'b0;
    ep_write   = 1'b0;
    ep_dataout = '0;
    m_ready    = 1'b0;

    // Reset / idle
    repeat (3) @(posedge okClk);
    #1 rst_n = 1'b1;
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_ep_ready", 32'(ep_ready), 1);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_underflow", 32'(underflow_seen), 0);

    // Ordered fill
    for (int i = 0; i < 16; i++) step(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
    chk("fill_full", 32'(full), 1);
    chk("fill_level", 32'(level), 16);
    chk("fill_ep_ready", 32'(ep_ready), 0);
    chk("fill_m_valid", 32'(m_valid), 1);
    chk("fill_head", m_data, 32'hA000_0000);

    // Overflow: write while full with a simultaneous pop is still dropped
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_level", 32'(level), 15);
    chk("ovf_full", 32'(full), 0);

    // Drain remaining words
    for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_level", 32'(level), 0);
    chk("drain_underflow_clean", 32'(underflow_seen), 0);
    chk("drain_ovf_sticky", 32'(overflow), 1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("underflow_set", 32'(underflow_seen), 1);
    chk("underflow_empty", 32'(empty), 1);

    // Wrap-around with steady push/pop at level 3
    for (int i = 0; i < 3; i++) step(1'b1, 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
    chk("wrap_prefill", 32'(level), 3);
    for (int i = 3; i < 43; i++) begin
      step(1'b1, 32'hB000_0000 + 32'(i), 1'b1, 1'b0);
      chk_level("wrap_level");
    end
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("wrap_drained", 32'(empty), 1);
    step(1'b0, '0, 1'b0, 1'b0);

    // Block throttle
    for (int i = 0; i < 12; i++) step(1'b1, 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
    chk("thr_level12", 32'(level), 12);
    chk("thr_ready_at12", 32'(ep_ready), 1);
    step(1'b1, 32'hC000_000C, 1'b0, 1'b0);
    chk("thr_level13", 32'(level), 13);
    chk("thr_ready_lag", 32'(ep_ready), 1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("thr_ready_low", 32'(ep_ready), 0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("thr_back12", 32'(level), 12);
    chk("thr_ready_still_low", 32'(ep_ready), 0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("thr_ready_back", 32'(ep_ready), 1);

    // Clear with a coincident write at level 7
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("clr_pre_level", 32'(level), 7);
    step(1'b1, 32'h0C1E_A500, 1'b0, 1'b1);
    chk("clr_level", 32'(level), 0);
    chk("clr_empty", 32'(empty), 1);
    chk("clr_overflow", 32'(overflow), 0);
    chk("clr_underflow", 32'(underflow_seen), 0);
    chk("clr_m_valid", 32'(m_valid), 0);
    step(1'b1, 32'h1111_1111, 1'b0, 1'b0);
    chk("clr_after_head", m_data, 32'h1111_1111);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("clr_after_empty", 32'(empty), 1);

    // Asynchronous reset between edges at level 5
    for (int i = 0; i < 5; i++) step(1'b1, 32'hE000_0000 + 32'(i), 1'b0, 1'b0);
    chk("arst_pre_level", 32'(level), 5);
    ep_write = 1'b0;
    m_ready  = 1'b0;
    rst_n    = 1'b0;
    #0.5;
    chk("arst_level", 32'(level), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_m_valid", 32'(m_valid), 0);
    #0.5;
    rst_n = 1'b1;
    exp_q.delete();
    step(1'b1, 32'h5A5A_0001, 1'b0, 1'b0);
    step(1'b1, 32'h5A5A_0002, 1'b0, 1'b0);
    chk("arst_first_word", m_data, 32'h5A5A_0001);
    chk("arst_level2", 32'(level), 2);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("final_empty", 32'(empty), 1);
    chk("final_queue", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/okpipe_in_fifo.md
Name: okpipe_in_fifo

Overview:
- Receive buffer directly downstream of the FrontPanel host interface on the XEM7310.
- Captures 32-bit words written by an okPipeIn/okBTPipeIn endpoint (`ep_write`/`ep_dataout`) into a circular FIFO.
- Presents the words to the processing pipeline as a valid/ready stream.
- Exports fill level and sticky status flags for a WireOut and the board LEDs.

Parameters:
- DATA_W, 32, word width; matches the okPipeIn data bus.
- DEPTH, 16, FIFO entries; power of two, minimum 4.
- BLOCK_WORDS, 4, block-throttled pipe burst size in words; 1 <= BLOCK_WORDS <= DEPTH.

Ports:
- okClk  in  1  host interface clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  one-cycle synchronous flush, from a TriggerIn.
- ep_write  in  1  pipe write strobe.
- ep_dataout  in  DATA_W  pipe write data.
- ep_ready  out  1  block-throttle ready to okBTPipeIn.
- m_data  out  DATA_W  head-of-FIFO word.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  downstream accepts the word.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- overflow  out  1  sticky: a write arrived while full.
- underflow_seen  out  1  sticky: m_ready was high while m_valid was low and `clear` was low. Diagnostic only.

Behaviour:
- Reset: while rst_n == 0, asynchronously set read/write pointers = 0, level = 0, overflow = 0, underflow_seen = 0.
  - Consequently m_valid = 0, empty = 1, full = 0, ep_ready = 1.
  - Storage array contents are not reset; m_data is don't-care while m_valid = 0.
- Reset asserted mid-transfer discards all contents immediately. The first write after deassertion lands at entry 0.
- Output style: first-word-fall-through. m_data = mem[rd_ptr] combinationally from registered storage; m_valid = !empty.
- Write latency: a word written on edge N is visible at m_data/m_valid after edge N, i.e. one cycle.
- Push: occurs when ep_write && !full, with full taken from the pre-edge value.
  - Writes mem[wr_ptr], then wr_ptr += 1 mod DEPTH.
- Write while full:
  - The word is dropped and no state changes except overflow <= 1.
  - A simultaneous pop does not rescue the write.
- Pop: occurs when m_valid && m_ready; rd_ptr += 1 mod DEPTH.
- Level update for simultaneous push and pop:
  - Both push and pop: level unchanged.
  - Push only: level + 1.
  - Pop only: level - 1.
- Pop while empty: no action; underflow_seen <= 1 (unless clear is high).
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. full and empty derive from level, not from pointer compare.
- ep_ready = (level <= DEPTH - BLOCK_WORDS), registered. It updates one cycle after level changes, so the host never starts a block that cannot fit.
  - BLOCK_WORDS == DEPTH gives ep_ready only when empty.
- clear:
  - Has priority over push and pop in the same cycle.
  - Resets pointers, level, overflow and underflow_seen, exactly as rst_n does, but synchronously.
  - A write coinciding with clear is discarded.
- Status outputs are driven from registers or from level only; there are no combinational paths from ep_write to any status output.
- No state machine beyond the counters. The FIFO is stateless apart from pointers, level and the sticky bits.

Decomposition:
- Shared package `okfifo_pkg` holds:
  - the default DATA_W/DEPTH constants;
  - a LEVEL_W function, $clog2(DEPTH)+1;
  - the status bit positions for the WireOut packing: {underflow_seen, overflow, full, empty} at bits [3:0].
- One natural sub-module: `okfifo_mem`, a simple dual-port register array. It has a write port (okClk, we, waddr, wdata) and an asynchronous read port (raddr, rdata).
- Pointer, level and flag logic stays in okpipe_in_fifo.

Test Plan:
- Reset/idle:
  - Stimulus: hold rst_n low 3 cycles, release.
  - Required: level=0, empty=1, full=0, m_valid=0, ep_ready=1, overflow=0.
- Ordered fill/drain:
  - Stimulus: write 0xA0000000..0xA000000F over 16 cycles with m_ready=0.
  - Required: full=1, level=16, ep_ready=0.
  - Then raise m_ready: m_data emerges 0xA0000000..0xA000000F in order, ending with empty=1.
- Overflow:
  - Stimulus: with FIFO full, write 0xDEADBEEF while m_ready=1 in the same cycle.
  - Required: overflow=1; level=15 after the pop; 0xDEADBEEF never appears at m_data.
- Wrap-around with simultaneous push/pop:
  - Stimulus: prefill 3 words, then 40 cycles with ep_write=1 and m_ready=1 (incrementing data).
  - Required: level stays 3, output sequence is exactly the input sequence delayed 3 words, pointers wrap at 16.
- Block throttle (BLOCK_WORDS=4):
  - Required: ep_ready=1 at level 12; ep_ready=0 one cycle after level reaches 13; ep_ready returns to 1 one cycle after level drops to 12.
- clear and mid-op reset:
  - clear with ep_write=1 at level 7 -> next cycle level=0, empty=1, overflow=0, and the written word is absent.
  - rst_n pulsed low for 1 ns between edges at level 5 -> level=0 immediately, without waiting for an okClk edge.
